fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decoder. Reads 16-bit instruction words as two byte transfers over the 8-bit memory bus, buffers them in a small queue, and presents each word together with its pc (address of the following word) to the decoder through a valid/ready handshake. Branch redirects flush the queue and restart fetching at the new address.

---
 rtl/fetch_unit_pkg.sv | 34 +++
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage types, state encodings and queue sizing.
// Queue depth is 2 when FETCH_PREFETCH_EN is defined, otherwise 1.
`default_nettype none

package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_LO   = 2'd0,
        FETCH_HI   = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_DROP = 2'd3
    } fetch_state_t;

`ifdef FETCH_PREFETCH_EN
    localparam int QUEUE_DEPTH = 2;
`else
    localparam int QUEUE_DEPTH = 1;
`endif

    // Wide enough to hold 0..2 for either depth.
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } fetch_entry_t;

    function automatic logic [15:0] even_addr(input logic [15:0] addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// fetch_queue: shift-register FIFO of {pc,word}; slot 0 is the registered head.
// Depth follows FETCH_PREFETCH_EN through the package default.
`default_nettype none

module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       push_data,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    logic [CNT_W-1:0] count_r;
    logic             pop_eff;
    logic [CNT_W-1:0] wr_idx;
    fetch_entry_t     slot_q [DEPTH];

    assign pop_eff = pop && (count_r != '0);
    // A simultaneous pop shifts everything down, so the write lands one lower.
    assign wr_idx  = count_r - CNT_W'(pop_eff);

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        fetch_entry_t slot_r;
        fetch_entry_t shift_in;

        if (i == DEPTH - 1) begin : g_tail
            assign shift_in = slot_r;
        end else begin : g_mid
            assign shift_in = slot_q[i+1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_r <= '0;
            end else if (!flush) begin
                if (push && (wr_idx == CNT_W'(i))) begin
                    slot_r <= push_data;
                end else if (pop_eff) begin
                    slot_r <= shift_in;
                end
            end
        end

        assign slot_q[i] = slot_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (flush) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(push) - CNT_W'(pop_eff);
        end
    end

    assign head  = slot_q[0];
    assign count = count_r;
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == '0);

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit: fetches 16-bit words as two byte reads and hands them to the decoder.
// FETCH_PREFETCH_EN selects a two-entry queue so fetching runs ahead of decoder stalls.
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_ack,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] word,
    output logic [15:0] pc,
    output logic        valid,
    input  logic        ready
);

    fetch_state_t     state;
    logic [15:0]      fptr;
    logic [7:0]       lo;

    logic             push;
    logic             pop;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W:0]   count_after;
    logic             room;
    fetch_entry_t     head;
    fetch_entry_t     push_data;

    assign pop         = valid && ready;
    // A redirect landing on the high-byte ack kills that word.
    assign push        = (state == FETCH_HI) && mem_rd && mem_ack && !redirect;
    assign push_data   = '{pc: fptr + 16'd2, word: {mem_data, lo}};
    assign count_after = {1'b0, q_count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
    assign room        = count_after < (CNT_W+1)'(QUEUE_DEPTH);

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data (push_data),
        .head      (head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign valid = !q_empty;
    assign word  = head.word;
    assign pc    = head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH_LO;
            fptr     <= even_addr(RESET_PC);
            lo       <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= even_addr(RESET_PC);
        end else if (redirect) begin
            fptr <= even_addr(redirect_pc);
            lo   <= '0;
            // An unanswered read must still be completed on the bus before moving on.
            if (mem_rd && !mem_ack) begin
                state <= FETCH_DROP;
            end else begin
                state    <= FETCH_LO;
                mem_rd   <= 1'b1;
                mem_addr <= even_addr(redirect_pc);
            end
        end else begin
            case (state)
                FETCH_LO: begin
                    if (!mem_rd) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= fptr;
                    end else if (mem_ack) begin
                        lo       <= mem_data;
                        state    <= FETCH_HI;
                        mem_addr <= fptr | 16'h0001;
                    end
                end
                FETCH_HI: begin
                    if (mem_ack) begin
                        fptr <= fptr + 16'd2;
                        if (room) begin
                            state    <= FETCH_LO;
                            mem_addr <= fptr + 16'd2;
                        end else begin
                            state  <= FETCH_WAIT;
                            mem_rd <= 1'b0;
                        end
                    end
                end
                FETCH_WAIT: begin
                    if (!q_full || pop) begin
                        state    <= FETCH_LO;
                        mem_rd   <= 1'b1;
                        mem_addr <= fptr;
                    end
                end
                FETCH_DROP: begin
                    if (mem_ack) begin
                        state    <= FETCH_LO;
                        mem_addr <= fptr;
                    end
                end
                default: begin
                    state  <= FETCH_LO;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a byte-memory reference.
`default_nettype none

module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0100;
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_ack;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] word;
    logic [15:0] pc;
    logic        valid;
    logic        ready;

    logic [7:0]  mem [65536];

    int vectors   = 0;
    int errors    = 0;
    int delivered = 0;
    int hi_acks   = 0;
    int lat_mode  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ack     (mem_ack),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .word        (word),
        .pc          (pc),
        .valid       (valid),
        .ready       (ready)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] a1;
        a1 = a + 16'd1;
        return {mem[a1], mem[a]};
    endfunction

    // Memory responder: answers each request after cur_lat extra cycles.
    initial begin
        int cnt;
        int cur_lat;
        cnt = 0;
        cur_lat = 0;
        mem_ack = 1'b0;
        mem_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n || !mem_rd) begin
                mem_ack = 1'b0;
                cnt = 0;
                cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end else if (cnt >= cur_lat) begin
                mem_ack = 1'b1;
                mem_data = mem[mem_addr];
                if (mem_addr[0]) hi_acks++;
                cnt = 0;
                cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end else begin
                mem_ack = 1'b0;
                cnt++;
            end
        end
    end

    // Reference stream: every accepted word must be the next sequential word.
    initial begin
        logic [15:0] exp_ptr;
        logic        prev_hold;
        logic [15:0] hold_word;
        logic [15:0] hold_pc;
        exp_ptr = RST_PC;
        prev_hold = 1'b0;
        hold_word = '0;
        hold_pc = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_ptr = RST_PC & 16'hFFFE;
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    vectors++;
                    if (valid !== 1'b1 || word !== hold_word || pc !== hold_pc) begin
                        errors++;
                        $display("FAIL hold_stable: got valid=%b word=%h pc=%h, need valid=1 word=%h pc=%h",
                                 valid, word, pc, hold_word, hold_pc);
                    end
                end
                if (valid && ready) begin
                    vectors++;
                    if (word !== mem_word(exp_ptr) || pc !== exp_ptr + 16'd2) begin
                        errors++;
                        $display("FAIL stream_word: got word=%h pc=%h, need word=%h pc=%h",
                                 word, pc, mem_word(exp_ptr), exp_ptr + 16'd2);
                    end
                    exp_ptr = exp_ptr + 16'd2;
                    delivered++;
                end
                prev_hold = valid && !ready && !redirect;
                hold_word = word;
                hold_pc = pc;
                if (redirect) exp_ptr = redirect_pc & 16'hFFFE;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [15:0] a);
        redirect = 1'b1;
        redirect_pc = a;
        tick();
        redirect = 1'b0;
    endtask

    task automatic settle(input int lat);
        lat_mode = lat;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        mem[16'h0100] = 8'h3C;
        mem[16'h0101] = 8'h12;
        rst_n = 1'b0;
        ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        lat_mode = 0;
        repeat (2) tick();
        vectors++;
        if (mem_rd !== 1'b0 || mem_addr !== 16'h0100 || valid !== 1'b0 || word !== 16'h0 || pc !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: got rd=%b addr=%h valid=%b word=%h pc=%h, need 0/0100/0/0000/0000",
                     mem_rd, mem_addr, valid, word, pc);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        vectors++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0100 || valid !== 1'b0) begin
            errors++;
            $display("FAIL first_read: got rd=%b addr=%h valid=%b, need 1/0100/0", mem_rd, mem_addr, valid);
        end
        tick();
        vectors++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0101 || valid !== 1'b0) begin
            errors++;
            $display("FAIL second_read: got rd=%b addr=%h valid=%b, need 1/0101/0", mem_rd, mem_addr, valid);
        end
        tick();
        vectors++;
        if (valid !== 1'b1 || word !== 16'h123C || pc !== 16'h0102) begin
            errors++;
            $display("FAIL first_word: got valid=%b word=%h pc=%h, need 1/123c/0102", valid, word, pc);
        end
    endtask

    task automatic test_throughput();
        int d0;
        ready = 1'b1;
        settle(0);
        do_redirect(16'h0500);
        repeat (6) tick();
        d0 = delivered;
        repeat (20) tick();
        vectors++;
        if ((DEPTH == 2 && (delivered - d0) != 10) || (DEPTH == 1 && ((delivered - d0) < 6 || (delivered - d0) > 7))) begin
            errors++;
            $display("FAIL throughput: got %0d words in 20 cycles, need %s", delivered - d0,
                     (DEPTH == 2) ? "10" : "6..7");
        end
    endtask

    task automatic test_stall();
        logic        seen;
        logic [15:0] w0;
        logic [15:0] p0;
        seen = 1'b0;
        w0 = '0;
        p0 = '0;
        ready = 1'b0;
        settle(0);
        do_redirect(16'h0400);
        hi_acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid && !seen) begin
                seen = 1'b1;
                w0 = word;
                p0 = pc;
            end else if (seen) begin
                vectors++;
                if (valid !== 1'b1 || word !== w0 || pc !== p0) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%b word=%h pc=%h, need 1/%h/%h", valid, word, pc, w0, p0);
                end
            end
        end
        vectors++;
        if (hi_acks != DEPTH || mem_rd !== 1'b0 || valid !== 1'b1 || word !== mem_word(16'h0400) || pc !== 16'h0402) begin
            errors++;
            $display("FAIL stall_fill: got words=%0d rd=%b valid=%b word=%h pc=%h, need %0d/0/1/%h/0402",
                     hi_acks, mem_rd, valid, word, pc, DEPTH, mem_word(16'h0400));
        end
        ready = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_redirect_drop();
        int  drop_cycles;
        int  n;
        logic found;
        found = 1'b0;
        drop_cycles = 0;
        ready = 1'b1;
        settle(3);
        do_redirect(16'h0300);
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_rd && mem_addr == 16'h0301) found = 1'b1;
            else tick();
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL drop_setup: got no HI read of 0301, need one within 20 cycles");
        end else begin
            do_redirect(16'h0201);
            vectors++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL drop_valid: got valid=%b after redirect, need 0", valid);
            end
            while (mem_addr == 16'h0301 && drop_cycles < 10) begin
                vectors++;
                if (mem_rd !== 1'b1 || valid !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_hold: got rd=%b valid=%b, need 1/0", mem_rd, valid);
                end
                drop_cycles++;
                tick();
            end
            vectors++;
            if (drop_cycles != 3 || mem_addr !== 16'h0200 || mem_rd !== 1'b1) begin
                errors++;
                $display("FAIL drop_exit: got %0d held cycles then addr=%h rd=%b, need 3 then 0200/1",
                         drop_cycles, mem_addr, mem_rd);
            end
        end
        n = 0;
        while (!valid && n < 30) begin
            tick();
            n++;
        end
        vectors++;
        if (valid !== 1'b1 || word !== mem_word(16'h0200) || pc !== 16'h0202) begin
            errors++;
            $display("FAIL drop_target: got valid=%b word=%h pc=%h, need 1/%h/0202", valid, word, pc, mem_word(16'h0200));
        end
        lat_mode = 0;
    endtask

    task automatic test_wrap();
        int n;
        ready = 1'b1;
        settle(0);
        do_redirect(16'hFFFE);
        vectors++;
        if (mem_addr !== 16'hFFFE || mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL wrap_lo: got addr=%h rd=%b, need fffe/1", mem_addr, mem_rd);
        end
        tick();
        vectors++;
        if (mem_addr !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_hi: got addr=%h, need ffff", mem_addr);
        end
        tick();
        vectors++;
        if (valid !== 1'b1 || word !== mem_word(16'hFFFE) || pc !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_word: got valid=%b word=%h pc=%h, need 1/%h/0000", valid, word, pc, mem_word(16'hFFFE));
        end
        n = 0;
        while (!(mem_rd && mem_addr != 16'hFFFF) && n < 5) begin
            tick();
            n++;
        end
        vectors++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_next: got addr=%h rd=%b, need 0000/1", mem_addr, mem_rd);
        end
    endtask

    task automatic test_redirect_handshake();
        logic found;
        int   n;
        found = 1'b0;
        ready = 1'b0;
        settle(0);
        do_redirect(16'h0600);
        for (int i = 0; i < 10 && !found; i++) begin
            if (mem_rd && mem_addr[0] && (valid || DEPTH == 1)) found = 1'b1;
            else tick();
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL rh_setup: got no HI read%s, need one within 10 cycles", (DEPTH == 2) ? " with valid" : "");
        end
        ready = 1'b1;
        do_redirect(16'h0700);
        vectors++;
        if (valid !== 1'b0 || mem_addr !== 16'h0700 || mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL rh_flush: got valid=%b addr=%h rd=%b, need 0/0700/1", valid, mem_addr, mem_rd);
        end
        n = 0;
        while (!valid && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if (valid !== 1'b1 || word !== mem_word(16'h0700) || pc !== 16'h0702) begin
            errors++;
            $display("FAIL rh_target: got valid=%b word=%h pc=%h, need 1/%h/0702", valid, word, pc, mem_word(16'h0700));
        end
    endtask

    task automatic test_async_reset();
        int n;
        ready = 1'b1;
        settle(0);
        do_redirect(16'h0800);
        n = 0;
        while (!mem_rd && n < 5) begin
            tick();
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (valid !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 16'h0100 || word !== 16'h0 || pc !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b rd=%b addr=%h word=%h pc=%h, need 0/0/0100/0000/0000",
                     valid, mem_rd, mem_addr, word, pc);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        vectors++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL reset_restart: got rd=%b addr=%h, need 1/0100", mem_rd, mem_addr);
        end
        repeat (2) tick();
        vectors++;
        if (valid !== 1'b1 || word !== mem_word(16'h0100) || pc !== 16'h0102) begin
            errors++;
            $display("FAIL reset_word: got valid=%b word=%h pc=%h, need 1/%h/0102", valid, word, pc, mem_word(16'h0100));
        end
    endtask

    task automatic test_random();
        int d0;
        d0 = delivered;
        lat_mode = -1;
        for (int i = 0; i < 600; i++) begin
            ready = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 24) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFA + 16'($urandom_range(0, 5)) : 16'($urandom);
            tick();
        end
        redirect = 1'b0;
        ready = 1'b1;
        repeat (20) tick();
        vectors++;
        if ((delivered - d0) < 40) begin
            errors++;
            $display("FAIL random_progress: got %0d words, need at least 40", delivered - d0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, need finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0;
        ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        test_reset();
        test_throughput();
        test_stall();
        test_redirect_drop();
        test_wrap();
        test_redirect_handshake();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
